// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU engine that owns HI/LO for the EX stage.
// Latency: start at edge E0, HI/LO written at E0+WIDTH+2; divide-by-zero flagged after E0+2.
// Backpressure: stall holds the pipeline while busy and an HI/LO reader or a new start is present.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             flush,
    input  logic             hilo_read,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t                 state, state_nxt;
    logic [1:0]             op_q;
    logic [WIDTH-1:0]       a_q, b_q;
    logic [2*WIDTH-1:0]     acc;
    logic                   sa, sb;
    logic [CW-1:0]          count;
    logic                   div0_pend;

    logic                   is_div, is_signed, b_zero, last_iter;
    logic [WIDTH-1:0]       a_abs, b_abs;
    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     mul_nxt;
    logic [WIDTH:0]         div_shift, div_diff;
    logic                   div_ge;
    logic [2*WIDTH-1:0]     div_nxt;
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       quo_fix, rem_fix;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign b_zero    = (b_q == '0);
    assign last_iter = (count == CW'(WIDTH-1));

    assign a_abs = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    assign b_abs = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
    assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient}; borrow bit decides the quotient bit.
    assign div_shift = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_ge    = ~div_diff[WIDTH];
    assign div_nxt   = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc[WIDTH-2:0], div_ge};

    assign prod_fix = (is_signed && (sa ^ sb)) ? -acc : acc;
    assign quo_fix  = (is_signed && (sa ^ sb)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = (is_signed && sa) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    assign busy  = (state != IDLE);
    assign stall = busy & (hilo_read | start);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start && !flush) state_nxt = PREP;
            PREP: begin
                if (flush || (is_div && b_zero)) state_nxt = IDLE;
                else                             state_nxt = RUN;
            end
            RUN: begin
                if (flush)          state_nxt = IDLE;
                else if (last_iter) state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            sa        <= 1'b0;
            sb        <= 1'b0;
            count     <= '0;
            div0_pend <= 1'b0;
            div0      <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            done      <= 1'b0;
            div0_pend <= 1'b0;
            div0      <= div0_pend;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        op_q <= op;
                        a_q  <= opa;
                        b_q  <= opb;
                    end
                end
                PREP: begin
                    sa    <= is_signed & a_q[WIDTH-1];
                    sb    <= is_signed & b_q[WIDTH-1];
                    acc   <= {{WIDTH{1'b0}}, a_abs};
                    b_q   <= b_abs;
                    count <= '0;
                    div0_pend <= ~flush & is_div & b_zero;
                end
                RUN: begin
                    if (!flush) begin
                        acc   <= is_div ? div_nxt : mul_nxt;
                        count <= count + CW'(1);
                    end
                end
                FIX: begin
                    if (!flush) begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table plus stall, back-to-back, flush and reset sequences.
module tb_muldiv_sequencer;

    logic        CLK, RST, start, flush, hilo_read;
    logic [1:0]  op;
    logic [31:0] opa, opb;
    logic        busy, stall, done, div0;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .start(start), .op(op), .opa(opa), .opb(opb),
        .flush(flush), .hilo_read(hilo_read), .busy(busy), .stall(stall),
        .done(done), .div0(div0), .hi(hi), .lo(lo)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at posedge+1 with the DUT idle; observes 40 cycles after the start edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int busy_n, output int done_n, output int done_k,
                          output int div0_n, output int div0_k,
                          output logic [31:0] hi_at, output logic [31:0] lo_at);
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge CLK); #1;
        start = 1'b0;
        busy_n = 0; done_n = 0; done_k = -1; div0_n = 0; div0_k = -1;
        for (int k = 0; k < 40; k++) begin
            if (busy) busy_n++;
            if (done) begin done_n++; done_k = k; end
            if (div0) begin div0_n++; div0_k = k; end
            @(posedge CLK); #1;
        end
        hi_at = hi;
        lo_at = lo;
    endtask

    initial begin
        int bn, dn, dk, zn, zk, cnt, dcnt;
        logic [31:0] h, l;

        vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[5]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[6]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[7]  = '{2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0};
        vecs[8]  = '{2'b11, 32'h0000_0451, 32'h0000_0020, 32'h0000_0011, 32'h0000_0022, 1'b0};
        vecs[9]  = '{2'b11, 32'd100,       32'd0,         32'h0000_0011, 32'h0000_0022, 1'b1};
        vecs[10] = '{2'b10, 32'd5,         32'd0,         32'h0000_0011, 32'h0000_0022, 1'b1};

        RST = 1'b0; start = 1'b0; flush = 1'b0; hilo_read = 1'b0;
        op = 2'b00; opa = '0; opb = '0;
        #12;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_div0", div0, 0);
        RST = 1'b1;
        @(posedge CLK); #1;

        // Flush beats start while idle
        start = 1'b1; flush = 1'b1; op = 2'b01; opa = 32'd3; opb = 32'd3;
        @(posedge CLK); #1;
        chk("idle_flush_busy", busy, 0);
        start = 1'b0; flush = 1'b0;
        @(posedge CLK); #1;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, bn, dn, dk, zn, zk, h, l);
            chk($sformatf("v%0d_hi", i), h, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), l, vecs[i].lo);
            chk($sformatf("v%0d_busy_cycles", i), bn, vecs[i].dz ? 1 : 34);
            chk($sformatf("v%0d_done_count", i), dn, vecs[i].dz ? 0 : 1);
            chk($sformatf("v%0d_done_cycle", i), dk, vecs[i].dz ? -1 : 34);
            chk($sformatf("v%0d_div0_count", i), zn, vecs[i].dz ? 1 : 0);
            chk($sformatf("v%0d_div0_cycle", i), zk, vecs[i].dz ? 2 : -1);
        end

        // MULTU 6*7 with an HI/LO reader right behind it
        start = 1'b1; op = 2'b01; opa = 32'd6; opb = 32'd7;
        @(posedge CLK); #1;
        start = 1'b0; hilo_read = 1'b1;
        cnt = 0;
        for (int k = 0; k < 34; k++) begin
            if (stall) cnt++;
            @(posedge CLK); #1;
        end
        chk("rd_stall_cycles", cnt, 34);
        chk("rd_stall_after_fix", stall, 0);
        chk("rd_done", done, 1);
        chk("rd_lo", lo, 42);
        chk("rd_hi", hi, 0);
        hilo_read = 1'b0;
        @(posedge CLK); #1;

        // Back-to-back: second start held by stall until the first idle cycle
        start = 1'b1; op = 2'b01; opa = 32'd3; opb = 32'd5;
        @(posedge CLK); #1;
        opa = 32'h0001_0000; opb = 32'h0001_0000;
        cnt = 0; dcnt = 0;
        for (int k = 0; k < 80; k++) begin
            if (k == 35) start = 1'b0;
            if (k < 34 && stall) cnt++;
            if (done) dcnt++;
            if (k == 34) begin
                chk("b2b_first_lo", lo, 15);
                chk("b2b_idle_gap_busy", busy, 0);
                chk("b2b_idle_gap_stall", stall, 0);
            end
            if (k == 35) chk("b2b_second_busy", busy, 1);
            @(posedge CLK); #1;
        end
        chk("b2b_stall_cycles", cnt, 34);
        chk("b2b_done_count", dcnt, 2);
        chk("b2b_final_hi", hi, 1);
        chk("b2b_final_lo", lo, 0);

        // Flush in RUN at count=10
        start = 1'b1; op = 2'b01; opa = 32'd5; opb = 32'd5;
        @(posedge CLK); #1;
        start = 1'b0;
        dcnt = 0; cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 11) flush = 1'b1;
            if (k == 12) begin
                chk("flush_busy", busy, 0);
                flush = 1'b0;
            end
            if (done) dcnt++;
            if (div0) cnt++;
            @(posedge CLK); #1;
        end
        chk("flush_done_count", dcnt, 0);
        chk("flush_div0_count", cnt, 0);
        chk("flush_hi", hi, 1);
        chk("flush_lo", lo, 0);

        // Asynchronous reset mid-RUN
        start = 1'b1; op = 2'b00; opa = 32'd9; opb = 32'd9;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (5) begin @(posedge CLK); #1; end
        chk("arst_pre_busy", busy, 1);
        #2 RST = 1'b0;
        #1;
        chk("arst_hi", hi, 0);
        chk("arst_lo", lo, 0);
        chk("arst_busy", busy, 0);
        @(posedge CLK); #3;
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("arst_after_busy", busy, 0);
        chk("arst_after_hi", hi, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
